// File: rtl/rvfi_trace_emitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rvfi_trace_emitter: turns writeback retirements (and late load data) into |
// | RVFI trace pulses. Define XCFI_RVFI_MEM_EN to trace mem fields / loads.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rvfi_trace_emitter #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [XLEN-1:0]     wb_insn,
    input  logic [XLEN-1:0]     wb_pc_rdata,
    input  logic [XLEN-1:0]     wb_pc_wdata,
    input  logic [4:0]          wb_rs1_addr,
    input  logic [4:0]          wb_rs2_addr,
    input  logic [4:0]          wb_rs3_addr,
    input  logic [4:0]          wb_rd_addr,
    input  logic [XLEN-1:0]     wb_rs1_rdata,
    input  logic [XLEN-1:0]     wb_rs2_rdata,
    input  logic [XLEN-1:0]     wb_rs3_rdata,
    input  logic [XLEN-1:0]     wb_rd_wdata,
    input  logic                wb_trap,
    input  logic                wb_load,
    input  logic [XLEN-1:0]     wb_mem_addr,
    input  logic [XLEN-1:0]     wb_mem_wdata,
    input  logic [XLEN/8-1:0]   wb_mem_rmask,
    input  logic [XLEN/8-1:0]   wb_mem_wmask,
    input  logic                ld_valid,
    input  logic [XLEN-1:0]     ld_rdata,
    input  logic                trap_entry,
    output logic                rvfi_valid,
    output logic [ORDER_W-1:0]  rvfi_order,
    output logic [XLEN-1:0]     rvfi_insn,
    output logic                rvfi_trap,
    output logic                rvfi_halt,
    output logic                rvfi_intr,
    output logic [XLEN-1:0]     rvfi_pc_rdata,
    output logic [XLEN-1:0]     rvfi_pc_wdata,
    output logic [4:0]          rvfi_rs1_addr,
    output logic [4:0]          rvfi_rs2_addr,
    output logic [4:0]          rvfi_rs3_addr,
    output logic [XLEN-1:0]     rvfi_rs1_rdata,
    output logic [XLEN-1:0]     rvfi_rs2_rdata,
    output logic [XLEN-1:0]     rvfi_rs3_rdata,
    output logic [4:0]          rvfi_rd_addr,
    output logic [XLEN-1:0]     rvfi_rd_wdata,
    output logic [XLEN-1:0]     rvfi_mem_addr,
    output logic [XLEN/8-1:0]   rvfi_mem_rmask,
    output logic [XLEN/8-1:0]   rvfi_mem_wmask,
    output logic [XLEN-1:0]     rvfi_mem_wdata
);
    typedef struct packed {
        logic [XLEN-1:0]   insn;
        logic              trap;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rs3_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [XLEN-1:0]   rs3_rdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_wdata;
    } trace_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    trace_t             wb_trace;
    trace_t             ld_trace;
    trace_t             hold;
    trace_t             trace;
    trace_t             out;
    logic               accept;
    logic               load_defer;
    logic               load_done;
    logic               emit;
    logic [ORDER_W-1:0] order_cnt;
    logic               intr_pend;

    assign wb_ready = (state == IDLE);
    assign accept   = wb_valid & wb_ready;

`ifdef XCFI_RVFI_MEM_EN
    assign load_defer = accept & wb_load & ~wb_trap;
    assign load_done  = (state == WAIT_LD) & ld_valid;
`else
    logic unused_mem;
    assign load_defer = 1'b0;
    assign load_done  = 1'b0;
    assign unused_mem = ^{wb_load, wb_mem_addr, wb_mem_wdata, wb_mem_rmask,
                          wb_mem_wmask, ld_valid, ld_rdata};
`endif

    assign emit = (accept & ~load_defer) | load_done;

    // A trap retires nothing architectural: rd and mem masks are squashed.
    always_comb begin
        wb_trace           = '0;
        wb_trace.insn      = wb_insn;
        wb_trace.trap      = wb_trap;
        wb_trace.pc_rdata  = wb_pc_rdata;
        wb_trace.pc_wdata  = wb_pc_wdata;
        wb_trace.rs1_addr  = wb_rs1_addr;
        wb_trace.rs2_addr  = wb_rs2_addr;
        wb_trace.rs3_addr  = wb_rs3_addr;
        wb_trace.rs1_rdata = wb_rs1_rdata;
        wb_trace.rs2_rdata = wb_rs2_rdata;
        wb_trace.rs3_rdata = wb_rs3_rdata;
        if (!wb_trap) begin
            wb_trace.rd_addr  = wb_rd_addr;
            wb_trace.rd_wdata = (wb_rd_addr == 5'd0) ? '0 : wb_rd_wdata;
        end
`ifdef XCFI_RVFI_MEM_EN
        wb_trace.mem_addr  = wb_mem_addr;
        wb_trace.mem_wdata = wb_mem_wdata;
        if (!wb_trap) begin
            wb_trace.mem_rmask = wb_mem_rmask;
            wb_trace.mem_wmask = wb_mem_wmask;
        end
`endif
    end

    always_comb begin
        ld_trace          = hold;
        ld_trace.rd_wdata = (hold.rd_addr == 5'd0) ? '0 : ld_rdata;
        trace             = load_done ? ld_trace : wb_trace;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_defer) state_next = WAIT_LD;
            WAIT_LD: if (load_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // trap_entry seen while emitting belongs to the following retirement.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rvfi_valid <= 1'b0;
            rvfi_order <= '0;
            rvfi_intr  <= 1'b0;
            out        <= '0;
            hold       <= '0;
            order_cnt  <= '0;
            intr_pend  <= 1'b0;
        end else begin
            rvfi_valid <= emit;
            if (load_defer) begin
                hold <= wb_trace;
            end
            if (emit) begin
                out        <= trace;
                rvfi_order <= order_cnt;
                order_cnt  <= order_cnt + ORDER_W'(1);
                rvfi_intr  <= intr_pend;
                intr_pend  <= trap_entry;
            end else if (trap_entry) begin
                intr_pend <= 1'b1;
            end
        end
    end

    assign rvfi_halt      = 1'b0;
    assign rvfi_insn      = out.insn;
    assign rvfi_trap      = out.trap;
    assign rvfi_pc_rdata  = out.pc_rdata;
    assign rvfi_pc_wdata  = out.pc_wdata;
    assign rvfi_rs1_addr  = out.rs1_addr;
    assign rvfi_rs2_addr  = out.rs2_addr;
    assign rvfi_rs3_addr  = out.rs3_addr;
    assign rvfi_rs1_rdata = out.rs1_rdata;
    assign rvfi_rs2_rdata = out.rs2_rdata;
    assign rvfi_rs3_rdata = out.rs3_rdata;
    assign rvfi_rd_addr   = out.rd_addr;
    assign rvfi_rd_wdata  = out.rd_wdata;
    assign rvfi_mem_addr  = out.mem_addr;
    assign rvfi_mem_rmask = out.mem_rmask;
    assign rvfi_mem_wmask = out.mem_wmask;
    assign rvfi_mem_wdata = out.mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_trace_emitter.sv
`default_nettype none
// tb_rvfi_trace_emitter: scoreboard bench for rvfi_trace_emitter; expectations
// follow XCFI_RVFI_MEM_EN when the bench is compiled with it.
module tb_rvfi_trace_emitter;
`ifdef XCFI_RVFI_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic g_clk = 1'b0;
    logic g_reset;
    logic wb_valid, wb_ready, wb_trap, wb_load, ld_valid, trap_entry;
    logic [31:0] wb_insn, wb_pc_rdata, wb_pc_wdata, wb_rs1_rdata, wb_rs2_rdata, wb_rs3_rdata, wb_rd_wdata;
    logic [4:0]  wb_rs1_addr, wb_rs2_addr, wb_rs3_addr, wb_rd_addr;
    logic [31:0] wb_mem_addr, wb_mem_wdata, ld_rdata;
    logic [3:0]  wb_mem_rmask, wb_mem_wmask;
    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [31:0] rvfi_mem_addr, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    always #5 g_clk = ~g_clk;

    rvfi_trace_emitter #(.XLEN(32), .ORDER_W(64)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_insn(wb_insn), .wb_pc_rdata(wb_pc_rdata), .wb_pc_wdata(wb_pc_wdata),
        .wb_rs1_addr(wb_rs1_addr), .wb_rs2_addr(wb_rs2_addr), .wb_rs3_addr(wb_rs3_addr),
        .wb_rd_addr(wb_rd_addr), .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
        .wb_rs3_rdata(wb_rs3_rdata), .wb_rd_wdata(wb_rd_wdata), .wb_trap(wb_trap),
        .wb_load(wb_load), .wb_mem_addr(wb_mem_addr), .wb_mem_wdata(wb_mem_wdata),
        .wb_mem_rmask(wb_mem_rmask), .wb_mem_wmask(wb_mem_wmask), .ld_valid(ld_valid),
        .ld_rdata(ld_rdata), .trap_entry(trap_entry), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rs1_addr(rvfi_rs1_addr),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    typedef struct packed {
        logic [31:0] insn, pc_rdata, pc_wdata;
        logic [4:0]  rs1_addr, rs2_addr, rs3_addr, rd_addr;
        logic [31:0] rs1_rdata, rs2_rdata, rs3_rdata, rd_wdata;
        logic        trap, load;
        logic [31:0] mem_addr, mem_wdata;
        logic [3:0]  mem_rmask, mem_wmask;
    } wb_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap, halt, intr;
        logic [31:0] pc_rdata, pc_wdata;
        logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
        logic [31:0] rs1_rdata, rs2_rdata, rs3_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata, mem_addr;
        logic [3:0]  mem_rmask, mem_wmask;
        logic [31:0] mem_wdata;
    } rec_t;

    logic [31:0] cyc = '0;
    rec_t        act_now;
    rec_t        exp_q[$];
    rec_t        obs_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_stall = 0;
    logic [63:0] exp_order = '0;
    logic        intr_pend = 1'b0;

    always @(posedge g_clk) cyc <= cyc + 32'd1;

    assign act_now = {cyc, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
                      rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr,
                      rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_addr, rvfi_rd_wdata,
                      rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_wdata};

    always @(negedge g_clk) if (rvfi_valid === 1'b1) obs_q.push_back(act_now);

    task automatic step();
        @(negedge g_clk);
        #1;
    endtask

    task automatic quiet();
        wb_valid = 1'b0; ld_valid = 1'b0; trap_entry = 1'b0;
    endtask

    function automatic wb_t rand_wb();
        wb_t w;
        w.insn = $urandom(); w.pc_rdata = $urandom(); w.pc_wdata = $urandom();
        w.rs1_addr = 5'($urandom()); w.rs2_addr = 5'($urandom()); w.rs3_addr = 5'($urandom());
        w.rd_addr = 5'($urandom_range(1, 31));
        w.rs1_rdata = $urandom(); w.rs2_rdata = $urandom(); w.rs3_rdata = $urandom();
        w.rd_wdata = $urandom(); w.trap = 1'b0; w.load = 1'b0;
        w.mem_addr = $urandom(); w.mem_wdata = $urandom();
        w.mem_rmask = 4'($urandom()); w.mem_wmask = 4'($urandom());
        return w;
    endfunction

    task automatic drive_wb(input wb_t w, input logic v);
        wb_valid = v; wb_insn = w.insn; wb_pc_rdata = w.pc_rdata; wb_pc_wdata = w.pc_wdata;
        wb_rs1_addr = w.rs1_addr; wb_rs2_addr = w.rs2_addr; wb_rs3_addr = w.rs3_addr;
        wb_rd_addr = w.rd_addr; wb_rs1_rdata = w.rs1_rdata; wb_rs2_rdata = w.rs2_rdata;
        wb_rs3_rdata = w.rs3_rdata; wb_rd_wdata = w.rd_wdata; wb_trap = w.trap; wb_load = w.load;
        wb_mem_addr = w.mem_addr; wb_mem_wdata = w.mem_wdata;
        wb_mem_rmask = w.mem_rmask; wb_mem_wmask = w.mem_wmask;
    endtask

    // Presents w until accepted; acc is the cycle stamp its pulse should carry.
    task automatic issue(input wb_t w, output logic [31:0] acc);
        bit ok = 1'b0;
        acc = '0;
        drive_wb(w, 1'b1);
        for (int i = 0; i < 20 && !ok; i++) begin
            if (wb_ready === 1'b1) begin
                ok = 1'b1;
                acc = cyc + 32'd1;
            end
            step();
        end
        if (!ok) n_stall++;
    endtask

    task automatic push_exp(input wb_t w, input logic [31:0] c, input logic from_ld, input logic [31:0] ld_data);
        rec_t e;
        e = '0;
        e.cyc = c; e.order = exp_order; e.insn = w.insn; e.trap = w.trap; e.intr = intr_pend;
        e.pc_rdata = w.pc_rdata; e.pc_wdata = w.pc_wdata;
        e.rs1_addr = w.rs1_addr; e.rs2_addr = w.rs2_addr; e.rs3_addr = w.rs3_addr;
        e.rs1_rdata = w.rs1_rdata; e.rs2_rdata = w.rs2_rdata; e.rs3_rdata = w.rs3_rdata;
        e.rd_addr = w.trap ? 5'd0 : w.rd_addr;
        e.rd_wdata = (e.rd_addr == 5'd0) ? 32'd0 : (from_ld ? ld_data : w.rd_wdata);
        if (MEM_EN) begin
            e.mem_addr = w.mem_addr; e.mem_wdata = w.mem_wdata;
            e.mem_rmask = w.trap ? 4'd0 : w.mem_rmask;
            e.mem_wmask = w.trap ? 4'd0 : w.mem_wmask;
        end
        exp_q.push_back(e);
        exp_order = exp_order + 64'd1;
        intr_pend = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (obs_q.size() >= exp_q.size()) ok = 1'b1;
            else step();
        end
    endtask

    task automatic apply_reset();
        quiet();
        g_reset = 1'b1;
        repeat (3) step();
        g_reset = 1'b0;
        exp_order = '0; intr_pend = 1'b0;
    endtask

    task automatic test_reset();
        drive_wb('0, 1'b0); ld_rdata = '0; quiet();
        g_reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (rvfi_valid !== 1'b0) begin n_bad++; $display("FAIL reset/valid_in_reset: got %b want 0", rvfi_valid); end
        g_reset = 1'b0;
        step();
        n_cmp++; if (rvfi_order !== 64'd0) begin n_bad++; $display("FAIL reset/order: got %h want 0", rvfi_order); end
        n_cmp++; if ({rvfi_insn, rvfi_rd_wdata, rvfi_pc_wdata, rvfi_intr, rvfi_halt} !== 98'd0) begin
            n_bad++; $display("FAIL reset/data: insn %h rd_wdata %h pc_wdata %h intr %b halt %b want all 0",
                              rvfi_insn, rvfi_rd_wdata, rvfi_pc_wdata, rvfi_intr, rvfi_halt);
        end
        n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset/ready: got %b want 1", wb_ready); end
        exp_order = '0; intr_pend = 1'b0; exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single();
        wb_t w; logic [31:0] acc; bit ok; rec_t e, a;
        w = rand_wb();
        w.insn = 32'h4C2282AB; w.pc_rdata = 32'h100; w.pc_wdata = 32'h104;
        w.rd_addr = 5'd5; w.rd_wdata = 32'h0001FFFF;
        issue(w, acc); quiet(); push_exp(w, acc, 1'b0, 32'd0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single/drain: pulses %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL single/trace: got %h want %h", a, e); end
        end
        exp_q.delete(); repeat (3) step();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single/extra: pulses %0d want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if ({rvfi_order, rvfi_rd_wdata, rvfi_pc_wdata} !== {64'd0, 32'h0001FFFF, 32'h104}) begin
            n_bad++; $display("FAIL single/fields: order %h rd_wdata %h pc_wdata %h want 0 0001ffff 104", rvfi_order, rvfi_rd_wdata, rvfi_pc_wdata);
        end
    endtask

    task automatic test_back_to_back();
        wb_t w; logic [31:0] acc; bit ok; rec_t e, a;
        for (int k = 0; k < 3; k++) begin
            w = rand_wb();
            if (k == 1) w.rd_addr = 5'd0;
            issue(w, acc); push_exp(w, acc, 1'b0, 32'd0);
        end
        quiet();
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b/drain: pulses %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL b2b/trace: got %h want %h", a, e); end
        end
        exp_q.delete(); repeat (3) step();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL b2b/extra: pulses %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_load();
        wb_t w; logic [31:0] acc, c; bit ok; rec_t e, a; int low;
        w = rand_wb();
        w.load = 1'b1; w.rd_addr = 5'd3; w.mem_rmask = 4'hF; w.mem_wmask = 4'h0;
        ld_valid = 1'b1; ld_rdata = 32'h0BAD0BAD; step();
        issue(w, acc);
        ld_valid = 1'b0; quiet();
        if (!MEM_EN) push_exp(w, acc, 1'b0, 32'd0);
        low = 0; c = '0;
        for (int k = 0; k < 4; k++) begin
            if (wb_ready === 1'b0) low++;
            if (k == 3) begin ld_valid = 1'b1; ld_rdata = 32'hDEADBEEF; c = cyc + 32'd1; end
            step();
        end
        ld_valid = 1'b0;
        if (MEM_EN) push_exp(w, c, 1'b1, 32'hDEADBEEF);
        n_cmp++; if (low !== (MEM_EN ? 4 : 0)) begin n_bad++; $display("FAIL load/ready_low: got %0d want %0d", low, MEM_EN ? 4 : 0); end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL load/drain: pulses %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL load/trace: got %h want %h", a, e); end
        end
        exp_q.delete(); repeat (3) step();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL load/extra: pulses %0d want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if ({rvfi_rd_wdata, rvfi_mem_rmask} !== {(MEM_EN ? 32'hDEADBEEF : w.rd_wdata), (MEM_EN ? 4'hF : 4'h0)}) begin
            n_bad++; $display("FAIL load/fields: rd_wdata %h rmask %h", rvfi_rd_wdata, rvfi_mem_rmask);
        end
    endtask

    task automatic test_rd0_trap();
        wb_t w; logic [31:0] acc; bit ok; rec_t e, a;
        w = rand_wb(); w.rd_addr = 5'd0; w.rd_wdata = 32'h12345678;
        issue(w, acc); quiet(); push_exp(w, acc, 1'b0, 32'd0);
        n_cmp++; if ({rvfi_valid, rvfi_rd_wdata} !== {1'b1, 32'd0}) begin
            n_bad++; $display("FAIL rd0/wdata: valid %b rd_wdata %h want 1 00000000", rvfi_valid, rvfi_rd_wdata);
        end
        w = rand_wb(); w.trap = 1'b1; w.load = 1'b1; w.rd_addr = 5'd7; w.mem_rmask = 4'hF;
        issue(w, acc); quiet(); push_exp(w, acc, 1'b0, 32'd0);
        n_cmp++; if ({wb_ready, rvfi_valid, rvfi_rd_addr, rvfi_trap, rvfi_mem_rmask} !== {1'b1, 1'b1, 5'd0, 1'b1, 4'd0}) begin
            n_bad++; $display("FAIL trap/fields: ready %b valid %b rd_addr %0d trap %b rmask %h want 1 1 0 1 0",
                              wb_ready, rvfi_valid, rvfi_rd_addr, rvfi_trap, rvfi_mem_rmask);
        end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd0trap/drain: pulses %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL rd0trap/trace: got %h want %h", a, e); end
        end
        exp_q.delete(); repeat (3) step();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rd0trap/extra: pulses %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_intr();
        wb_t w; logic [31:0] acc; bit ok; rec_t e, a;
        trap_entry = 1'b1; intr_pend = 1'b1; step();
        trap_entry = 1'b0; step();
        w = rand_wb(); w.pc_rdata = 32'h80;
        issue(w, acc); push_exp(w, acc, 1'b0, 32'd0);
        n_cmp++; if (rvfi_intr !== 1'b1) begin n_bad++; $display("FAIL intr/first: got %b want 1", rvfi_intr); end
        w = rand_wb(); trap_entry = 1'b1;
        issue(w, acc); trap_entry = 1'b0; push_exp(w, acc, 1'b0, 32'd0); intr_pend = 1'b1;
        n_cmp++; if (rvfi_intr !== 1'b0) begin n_bad++; $display("FAIL intr/coincident: got %b want 0", rvfi_intr); end
        for (int k = 0; k < 2; k++) begin
            w = rand_wb(); issue(w, acc); push_exp(w, acc, 1'b0, 32'd0);
        end
        quiet();
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL intr/drain: pulses %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL intr/trace: got %h want %h", a, e); end
        end
        exp_q.delete(); repeat (3) step();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL intr/extra: pulses %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_wait();
        wb_t w; logic [31:0] acc; bit ok; rec_t e, a;
        apply_reset(); step();
        w = rand_wb(); w.load = 1'b1; w.rd_addr = 5'd9;
        issue(w, acc); quiet();
        if (!MEM_EN) push_exp(w, acc, 1'b0, 32'd0);
        wait_drain(ok);
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL rstwait/pre_trace: got %h want %h", a, e); end
        end
        exp_q.delete(); obs_q.delete();
        apply_reset();
        ld_valid = 1'b1; ld_rdata = 32'hCAFEF00D;
        repeat (3) step();
        ld_valid = 1'b0;
        n_cmp++; if ({obs_q.size() == 0, rvfi_order, wb_ready} !== {1'b1, 64'd0, 1'b1}) begin
            n_bad++; $display("FAIL rstwait/discard: pulses %0d order %h ready %b want 0 0 1", obs_q.size(), rvfi_order, wb_ready);
        end
        obs_q.delete();
        w = rand_wb(); issue(w, acc); quiet(); push_exp(w, acc, 1'b0, 32'd0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstwait/drain: pulses %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL rstwait/trace: got %h want %h", a, e); end
        end
        exp_q.delete(); repeat (3) step();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rstwait/extra: pulses %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_load();
        test_rd0_trap();
        test_intr();
        test_reset_wait();
        n_cmp++; if (n_stall != 0) begin n_bad++; $display("FAIL issue/accept_timeout: stalls %0d want 0", n_stall); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
